// File: rtl/muldiv_hilo_ctrl_if.sv
// Request/response bundle between decode/execute and the HI/LO mul/div sequencer.
interface muldiv_hilo_ctrl_if;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        op_ready;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op_valid, op_code, rs_data, rt_data,
    input  op_ready, busy, done, hi, lo
  );

  modport slave (
    input  op_valid, op_code, rs_data, rt_data,
    output op_ready, busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO owner: radix-2 shift-add multiplier and restoring divider, 32 iterations.
// MULDIV_FAST_MULT_EN: MULT/MULTU form the product in PREP and skip ITER.
module muldiv_hilo_ctrl (
  input  logic               clk,
  input  logic               reset_n,
  muldiv_hilo_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIXUP} state_t;

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  state_t      state;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [63:0] acc;
  logic [4:0]  cnt;
  logic        res_neg, rem_neg, div0;
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  logic        is_div, is_signed;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [32:0] div_sh, div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];

  always_comb begin
    mag_a    = (is_signed && a_q[31]) ? -a_q : a_q;
    mag_b    = (is_signed && b_q[31]) ? -b_q : b_q;
    // multiplier bits are consumed from acc[0]; carry lands in acc[63]
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_q} : 33'd0);
    // remainder sits in acc[63:32], dividend/quotient shifts through acc[31:0]
    div_sh   = {acc[63:32], acc[31]};
    div_diff = div_sh - {1'b0, b_q};
    prod_fix = res_neg ? -acc : acc;
    quo_fix  = res_neg ? -acc[31:0]  : acc[31:0];
    rem_fix  = rem_neg ? -acc[63:32] : acc[63:32];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      cnt     <= '0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      div0    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.op_valid) begin
            if (bus.op_code[2] == 1'b0) begin
              op_q  <= bus.op_code[1:0];
              a_q   <= bus.rs_data;
              b_q   <= bus.rt_data;
              state <= PREP;
            end else if (bus.op_code == OP_MTHI) begin
              hi_q <= bus.rs_data;
            end else if (bus.op_code == OP_MTLO) begin
              lo_q <= bus.rs_data;
            end
          end
        end
        PREP: begin
          res_neg <= is_signed & (a_q[31] ^ b_q[31]);
          rem_neg <= is_signed & a_q[31];
          cnt     <= 5'd31;
          if (is_div && b_q == 32'd0) begin
            // a_q keeps the raw dividend for HI
            div0  <= 1'b1;
            state <= FIXUP;
          end else begin
            div0 <= 1'b0;
            a_q  <= mag_a;
            b_q  <= mag_b;
            acc  <= is_div ? {32'd0, mag_a} : {32'd0, mag_b};
`ifdef MULDIV_FAST_MULT_EN
            if (!is_div) begin
              acc   <= {32'd0, mag_a} * {32'd0, mag_b};
              state <= FIXUP;
            end else begin
              state <= ITER;
            end
`else
            state <= ITER;
`endif
          end
        end
        ITER: begin
          if (is_div) begin
            if (!div_diff[32]) acc <= {div_diff[31:0], acc[30:0], 1'b1};
            else               acc <= {div_sh[31:0],   acc[30:0], 1'b0};
          end else begin
            acc <= {mul_sum, acc[31:1]};
          end
          if (cnt == 5'd0) state <= FIXUP;
          else             cnt   <= cnt - 5'd1;
        end
        FIXUP: begin
          if (div0) begin
            hi_q <= a_q;
            lo_q <= 32'hFFFF_FFFF;
          end else if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.op_ready = (state == IDLE);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Randomized + directed bench for muldiv_hilo_ctrl against a plain-arithmetic HI/LO model.
module tb_muldiv_hilo_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  muldiv_hilo_ctrl_if bus();
  muldiv_hilo_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    model = '0;
    case (op)
      3'd0: begin p = sa * sb; model = p; end
      3'd1: begin u = {32'd0, a} * {32'd0, b}; model = u; end
      3'd2: begin
        if (b == 0) model = {a, 32'hFFFF_FFFF};
        else begin q = sa / sb; r = sa % sb; model = {r[31:0], q[31:0]}; end
      end
      3'd3: begin
        if (b == 0) model = {a, 32'hFFFF_FFFF};
        else model = {a % b, a / b};
      end
      default: model = '0;
    endcase
  endfunction

  function automatic int exp_busy(input logic [2:0] op, input logic [31:0] b);
    if (op >= 3'd4) return 0;
    if (op <= 3'd1) begin
`ifdef MULDIV_FAST_MULT_EN
      return 2;
`else
      return 34;
`endif
    end
    return (b == 0) ? 2 : 34;
  endfunction

  // waits out busy, checks cycle count, stability, done and committed HI/LO
  task automatic wait_commit(input string tag, input int nb, input logic [63:0] e);
    int n;
    logic stable;
    logic [31:0] h0, l0;
    h0 = bus.hi; l0 = bus.lo;
    n = 0; stable = 1'b1;
    while (bus.busy && n < 100) begin
      if (bus.hi !== h0 || bus.lo !== l0) stable = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " busy_cycles"}, 64'(n), 64'(nb));
    chk({tag, " hilo_stable"}, {63'd0, stable}, 64'd1);
    chk({tag, " done"}, {63'd0, bus.done}, 64'd1);
    chk({tag, " hilo"}, {bus.hi, bus.lo}, e);
    m_hi = e[63:32]; m_lo = e[31:0];
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = op; bus.rs_data = a; bus.rt_data = b;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    if (op >= 3'd4) begin
      if (op == 3'd4) m_hi = a;
      if (op == 3'd5) m_lo = a;
      chk({tag, " busy"}, {63'd0, bus.busy}, 64'd0);
      chk({tag, " done"}, {63'd0, bus.done}, 64'd0);
      chk({tag, " hilo"}, {bus.hi, bus.lo}, {m_hi, m_lo});
    end else begin
      wait_commit(tag, exp_busy(op, b), model(op, a, b));
      @(posedge clk); #1;
      chk({tag, " done_pulse"}, {63'd0, bus.done}, 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] op;
    logic [31:0] a, b;
    logic seen;
    bus.op_valid = 1'b0; bus.op_code = '0; bus.rs_data = '0; bus.rt_data = '0;
    #2 reset_n = 1'b0;
    #3;
    chk("rst op_ready", {63'd0, bus.op_ready}, 64'd1);
    chk("rst busy", {63'd0, bus.busy}, 64'd0);
    chk("rst done", {63'd0, bus.done}, 64'd0);
    chk("rst hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk); reset_n = 1'b1;

    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max lit", {m_hi, m_lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg", 3'd0, 32'hFFFF_FFF9, 32'd3);
    chk("mult_neg lit", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg lit", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_zero", 3'd3, 32'd100, 32'd0);
    chk("divu_zero lit", {m_hi, m_lo}, 64'h0000_0064_FFFF_FFFF);
    run_op("div_zero", 3'd2, 32'h8765_4321, 32'd0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf lit", {m_hi, m_lo}, 64'h0000_0000_8000_0000);
    run_op("mthi", 3'd4, 32'h1234_5678, 32'd0);
    run_op("mtlo", 3'd5, 32'h9ABC_DEF0, 32'd0);
    chk("mthilo lit", {bus.hi, bus.lo}, 64'h1234_5678_9ABC_DEF0);
    run_op("op6", 3'd6, 32'hDEAD_BEEF, 32'd1);
    run_op("op7", 3'd7, 32'hCAFE_F00D, 32'd2);

    // DIVU issued, then MULT held through busy: accepted only once ready returns
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = 3'd3; bus.rs_data = 32'd17; bus.rt_data = 32'd5;
    @(posedge clk); #1;
    bus.op_code = 3'd0; bus.rs_data = 32'd6; bus.rt_data = 32'd7;
    wait_commit("held_divu", 34, 64'h0000_0002_0000_0003);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    chk("held_mult accepted", {63'd0, bus.busy}, 64'd1);
    wait_commit("held_mult", exp_busy(3'd0, 32'd7), 64'd42);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: a = 32'($urandom_range(0, 300));
        1: a = 32'h8000_0000 | 32'($urandom_range(0, 3));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b);
    end

    // async reset mid-ITER discards the operation
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = 3'd1; bus.rs_data = 32'h0001_2345; bus.rt_data = 32'h0000_F00F;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk); reset_n = 1'b0;
    #1;
    chk("midrst busy", {63'd0, bus.busy}, 64'd0);
    chk("midrst hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk); reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk("midrst no_done", {63'd0, seen}, 64'd0);
    chk("midrst ready", {63'd0, bus.op_ready}, 64'd1);

    run_op("post_rst_mult", 3'd0, 32'h7FFF_FFFF, 32'h8000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
